// File: rtl/mem_resp_pkg.sv
// Shared types, size encodings and request classification for the memory responder.
package mem_resp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRead,
        StWrite,
        StResp
    } state_e;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    // A request is rejected for a reserved size, a misaligned access, or an
    // address that reaches beyond the decoded byte-address range.
    function automatic logic req_is_err(input logic [31:0] addr,
                                        input logic [1:0]  size,
                                        input int unsigned addr_w);
        logic        err;
        logic [31:0] hi_mask;
        case (size)
            SIZE_WORD: err = (addr[1:0] != 2'b00);
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr[0];
            default:   err = 1'b1;
        endcase
        hi_mask = ~((32'd1 << addr_w) - 32'd1);
        if ((addr & hi_mask) != 32'd0) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Big-endian byte/halfword merge of right-aligned write data into a stored word.
module mem_lane_merge
    import mem_resp_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] merged_word
);

    // Replace only the addressed lane; byte lane 0 is the most significant byte.
    always_comb begin
        merged_word = old_word;
        case (size)
            SIZE_WORD: merged_word = wdata;
            SIZE_BYTE: begin
                case (addr_lo)
                    2'b00:   merged_word[31:24] = wdata[7:0];
                    2'b01:   merged_word[23:16] = wdata[7:0];
                    2'b10:   merged_word[15:8]  = wdata[7:0];
                    default: merged_word[7:0]   = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_lo[1]) begin
                    merged_word[15:0] = wdata[15:0];
                end else begin
                    merged_word[31:16] = wdata[15:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time, subword writes merged in place.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned WORDS     = 1 << (ADDR_W - 2);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_e              state_q;
    logic [3:0]          wait_cnt_q;
    logic                rd_phase_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [31:0]         hold_q;
    logic [31:0]         rd_word;
    logic [31:0]         merged;
    logic [ADDR_W-3:0]   idx;

    logic [31:0]         mem [WORDS];

    assign idx = addr_q[ADDR_W-1:2];

    mem_lane_merge u_merge (
        .old_word    (hold_q),
        .wdata       (wdata_q),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .merged_word (merged)
    );

    // Storage with a registered read port; only the WRITE state commits, so an
    // asynchronous reset can never leave a half-finished write behind.
    always_ff @(posedge Clk) begin
        if (state_q == StWrite) begin
            mem[idx] <= merged;
        end
        rd_word <= mem[idx];
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            rd_phase_q <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            size_q     <= SIZE_WORD;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            hold_q     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q     <= req_addr[ADDR_W-1:0];
                        wr_q       <= req_wr;
                        size_q     <= req_size;
                        wdata_q    <= req_wdata;
                        err_q      <= req_is_err(req_addr, req_size, ADDR_W);
                        wait_cnt_q <= '0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= (WAIT_CYCLES == 0) ? StRead : StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_q <= '0;
                        state_q    <= StRead;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StRead: begin
                    // First cycle lets the registered read port settle on the
                    // captured address; the second captures it.
                    if (!rd_phase_q) begin
                        rd_phase_q <= 1'b1;
                    end else begin
                        rd_phase_q <= 1'b0;
                        hold_q     <= err_q ? 32'd0 : rd_word;
                        if (wr_q && !err_q) begin
                            state_q <= StWrite;
                        end else begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= err_q;
                            resp_rdata <= err_q ? 32'd0 : rd_word;
                        end
                    end
                end
                StWrite: begin
                    hold_q     <= merged;
                    state_q    <= StResp;
                    resp_valid <= 1'b1;
                    resp_rdata <= merged;
                end
                StResp: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus reset and zero-wait sequences.
module tb_mem_responder;
    import mem_resp_pkg::*;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_wr = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        z_valid = 1'b0, z_wr = 1'b0;
    logic [31:0] z_addr = '0, z_wdata = '0;
    logic [1:0]  z_size = '0;
    logic        z_ready, z_resp_valid, z_resp_err, z_busy;
    logic [31:0] z_resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_z (
        .Clk        (Clk),
        .reset      (reset),
        .req_valid  (z_valid),
        .req_wr     (z_wr),
        .req_addr   (z_addr),
        .req_size   (z_size),
        .req_wdata  (z_wdata),
        .req_ready  (z_ready),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err),
        .busy       (z_busy)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request on the WAIT_CYCLES=2 instance and check the response.
    task automatic do_req(input string name, input logic wr, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int          n;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        @(negedge Clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(posedge Clk);
        #1;
        // Scramble inputs after acceptance; the block must use the captured copy.
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = addr ^ 32'h0000_0044;
        req_size  = 2'b11;
        req_wdata = ~wdata;
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk);
            #1;
            if (resp_valid) begin
                lat   = i;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " rdata"}, rdata, exp_rdata);
        check({name, " err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge Clk);
        #1;
        check({name, " valid one cycle"}, {31'd0, resp_valid}, 32'd0);
        check({name, " rdata held"}, resp_rdata, exp_rdata);
    endtask

    initial begin
        logic [5:0]  zb;
        int          lat;
        int          n;
        int          acc;
        int          acc_edge[2];
        logic        rdy_before;
        logic        seen;

        vecs[0]  = '{1'b1, 32'h10,  SIZE_WORD, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5};
        vecs[1]  = '{1'b0, 32'h10,  SIZE_WORD, 32'h0,        32'hDEADBEEF, 1'b0, 4};
        vecs[2]  = '{1'b1, 32'h11,  SIZE_BYTE, 32'h000000AA, 32'hDEAABEEF, 1'b0, 5};
        vecs[3]  = '{1'b0, 32'h10,  SIZE_WORD, 32'h0,        32'hDEAABEEF, 1'b0, 4};
        vecs[4]  = '{1'b1, 32'h12,  SIZE_HALF, 32'h00001234, 32'hDEAA1234, 1'b0, 5};
        vecs[5]  = '{1'b0, 32'h10,  SIZE_WORD, 32'h0,        32'hDEAA1234, 1'b0, 4};
        vecs[6]  = '{1'b1, 32'h13,  SIZE_HALF, 32'h00005678, 32'h0,        1'b1, 4};
        vecs[7]  = '{1'b0, 32'h10,  2'b11,     32'h0,        32'h0,        1'b1, 4};
        vecs[8]  = '{1'b1, 32'h100, SIZE_WORD, 32'h0BADF00D, 32'h0,        1'b1, 4};
        vecs[9]  = '{1'b0, 32'h10,  SIZE_WORD, 32'h0,        32'hDEAA1234, 1'b0, 4};
        vecs[10] = '{1'b1, 32'h20,  SIZE_WORD, 32'h11223344, 32'h11223344, 1'b0, 5};
        vecs[11] = '{1'b1, 32'h23,  SIZE_BYTE, 32'hFFFFFF55, 32'h11223355, 1'b0, 5};
        vecs[12] = '{1'b1, 32'h20,  SIZE_HALF, 32'hFFFFABCD, 32'hABCD3355, 1'b0, 5};
        vecs[13] = '{1'b1, 32'h20,  SIZE_BYTE, 32'h00000077, 32'h77CD3355, 1'b0, 5};
        vecs[14] = '{1'b1, 32'h22,  SIZE_WORD, 32'h12345678, 32'h0,        1'b1, 4};
        vecs[15] = '{1'b0, 32'h21,  SIZE_BYTE, 32'h0,        32'h77CD3355, 1'b0, 4};
        vecs[16] = '{1'b1, 32'hFC,  SIZE_WORD, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 5};
        vecs[17] = '{1'b0, 32'hFC,  SIZE_WORD, 32'h0,        32'hCAFEF00D, 1'b0, 4};
        vecs[18] = '{1'b0, 32'h20,  SIZE_WORD, 32'h0,        32'h77CD3355, 1'b0, 4};
        vecs[19] = '{1'b1, 32'h30,  SIZE_WORD, 32'h01020304, 32'h01020304, 1'b0, 5};
        vecs[20] = '{1'b0, 32'h1FC, SIZE_WORD, 32'h0,        32'h0,        1'b1, 4};

        // Power-on reset.
        #2 reset = 1'b0;
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", {31'd0, resp_err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge Clk);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            do_req($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Reset during WAIT of a read: outputs drop at once, request is dropped.
        @(negedge Clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_size = SIZE_WORD;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        check("mid busy in wait", {31'd0, busy}, 32'd1);
        check("mid ready in wait", {31'd0, req_ready}, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset req_ready", {31'd0, req_ready}, 32'd1);
        check("mid reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid reset resp_rdata", resp_rdata, 32'd0);
        check("mid reset resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge Clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check("aborted no resp", {31'd0, seen}, 32'd0);
        check("after abort ready", {31'd0, req_ready}, 32'd1);

        // Reset in READ of a write: the word must stay untouched.
        @(negedge Clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30; req_size = SIZE_WORD;
        req_wdata = 32'hFFFFFFFF;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        #2 reset = 1'b0;
        #1;
        check("abort wr busy", {31'd0, busy}, 32'd0);
        @(negedge Clk);
        reset = 1'b1;
        do_req("abort wr readback", 1'b0, 32'h30, SIZE_WORD, 32'h0, 32'h01020304, 1'b0, 4);

        // Zero-wait instance: a write first so the later read has known data.
        @(negedge Clk);
        check("z ready idle", {31'd0, z_ready}, 32'd1);
        z_valid = 1'b1; z_wr = 1'b1; z_addr = 32'h4; z_size = SIZE_WORD; z_wdata = 32'h00C0FFEE;
        @(posedge Clk);
        #1;
        z_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk);
            #1;
            if (z_resp_valid) begin
                lat = i;
                break;
            end
        end
        check("z wr latency", 32'(lat), 32'd3);
        @(negedge Clk);
        n = 0;
        while (!z_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end

        // Hold a read request for six edges: accepted at edges 0 and 4 only.
        zb = 6'b110111;
        z_valid = 1'b1; z_wr = 1'b0; z_addr = 32'h4; z_size = SIZE_WORD;
        acc = 0;
        acc_edge[0] = -1;
        acc_edge[1] = -1;
        for (int e = 0; e < 6; e++) begin
            rdy_before = z_ready;
            @(posedge Clk);
            #1;
            if (rdy_before) begin
                if (acc < 2) acc_edge[acc] = e;
                acc++;
            end
            check($sformatf("z busy e%0d", e), {31'd0, z_busy}, {31'd0, zb[e]});
            check($sformatf("z ready e%0d", e), {31'd0, z_ready}, {31'd0, ~zb[e]});
            check($sformatf("z valid e%0d", e), {31'd0, z_resp_valid}, (e == 2) ? 32'd1 : 32'd0);
            if (e == 2) check("z rd rdata", z_resp_rdata, 32'h00C0FFEE);
            @(negedge Clk);
        end
        z_valid = 1'b0;
        check("z accept count", 32'(acc), 32'd2);
        check("z first accept", 32'(acc_edge[0]), 32'd0);
        check("z second accept", 32'(acc_edge[1]), 32'd4);
        @(posedge Clk);
        #1;
        check("z second resp", {31'd0, z_resp_valid}, 32'd1);
        check("z second rdata", z_resp_rdata, 32'h00C0FFEE);
        check("z second err", {31'd0, z_resp_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
